msg_encrypt: RTL and testbench
==============================

MSG_ENCRYPT -- requirements
Module: msg_encrypt

Interface
REQ-001 The module SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 The module SHALL have port init, input, 1 bit: reset, asynchronous and active-high.
REQ-003 The module SHALL have port start, input, 1 bit: one-cycle request to begin encryption; sampled only in IDLE.
REQ-004 The module SHALL have port taps_sel, input, 3 bits: LFSR tap pattern index, 0..5.
REQ-005 The module SHALL have port seed, input, 6 bits: LFSR starting state.
REQ-006 The module SHALL have port pre_len, input, 4 bits: preamble length in characters, 0..15.
REQ-007 The module SHALL have port data_out, input, 8 bits: plaintext byte from data memory; memory read is combinational on raddr.
REQ-008 The module SHALL have port raddr, output, 8 bits: memory read address.
REQ-009 The module SHALL have port waddr, output, 8 bits: memory write address.
REQ-010 The module SHALL have port data_in, output, 8 bits: encrypted byte to memory.
REQ-011 The module SHALL have port wr_en, output, 1 bit: memory write strobe; memory writes on the rising clk edge.
REQ-012 The module SHALL have port done, output, 1 bit: encryption complete, registered level.
REQ-013 The module SHALL have port err, output, 1 bit: last start was rejected for taps_sel > 5.

Function
REQ-014 The block SHALL use a 3-state FSM: IDLE, RUN, DONE.
REQ-015 In IDLE with start=1 and taps_sel<=5, the block SHALL latch taps, seed and pre_len, clear cnt to 0, clear err, and enter RUN on that edge.
REQ-016 In IDLE with start=1 and taps_sel>5, the block SHALL set err=1 and stay in IDLE.
REQ-017 The tap table SHALL be 0:6'h21, 1:6'h2D, 2:6'h30, 3:6'h33, 4:6'h36, 5:6'h39.
REQ-018 A latched seed of 6'h00 SHALL be replaced by 6'h01, so the LFSR never locks up.
REQ-019 The LFSR next state SHALL be {state[4:0], ^(state & taps)}; it advances once per RUN cycle.
REQ-020 The 6-bit counter cnt SHALL run 0..63 in RUN, with one write per cycle: wr_en=1 and waddr=64+cnt.
REQ-021 For cnt < pre_len, data_in SHALL be 8'h5F ^ {2'b00, lfsr} and raddr SHALL be 0.
REQ-022 For cnt >= pre_len, raddr SHALL be cnt - pre_len (6-bit, zero-extended) and data_in SHALL be data_out ^ {2'b00, lfsr}.
REQ-023 On the RUN edge where cnt=63, the FSM SHALL go to DONE, making exactly 64 writes in total; addresses never wrap past 127.
REQ-024 In DONE, done SHALL be 1 and wr_en 0; start=1 in DONE SHALL behave as in IDLE (REQ-015/016) and clear done.
REQ-025 Latency: start is sampled at edge E0; the first write is at edge E1 and the last write at E64; done is high after E64.
REQ-026 start during RUN SHALL be ignored; input changes during RUN SHALL have no effect (values are latched).
REQ-027 Outside RUN, wr_en SHALL be 0; raddr, waddr and data_in SHALL be 0.

Reset
REQ-028 init=1 SHALL immediately force IDLE, cnt=0, lfsr=6'h01, done=0, err=0 and wr_en=0, without waiting for clk.
REQ-029 init asserted mid-RUN SHALL abort the run with no further writes; a later start SHALL restart from cnt=0.
REQ-030 start SHALL be ignored while init=1.

Verification
REQ-031 The bench SHALL cover: taps_sel=0, seed=6'h01, pre_len=7, start -> mem[64]=8'h5E, mem[65]=8'h5C, done rises after 64th write.
REQ-032 The bench SHALL cover: taps_sel=2, seed=6'h3F, pre_len=0, mem[0]=8'h41 -> mem[64]=8'h7E; raddr equals cnt throughout.
REQ-033 The bench SHALL cover: taps_sel=6, start -> err=1, no wr_en pulse, FSM stays IDLE; then taps_sel=1, start -> err=0, run proceeds.
REQ-034 The bench SHALL cover: seed=6'h00, taps_sel=0, pre_len=1 -> mem[64]=8'h5E, identical to the seed=6'h01 result.
REQ-035 The bench SHALL cover: init pulsed at cnt=20 -> wr_en falls asynchronously, mem[85..127] unchanged, done=0.
REQ-036 The bench SHALL cover: round trip for all 6 taps with pre_len=10 -> decrypting mem[64..127] with the reference LFSR model yields ten 8'h5F then mem[0..53].

Source files
------------

// File: rtl/msg_encrypt.sv
// LFSR stream cipher: writes a keyed preamble plus 64-preamble plaintext bytes to mem[64..127].
// Latency: first write one cycle after start, 64 writes back to back; no backpressure, memory always accepts.
module msg_encrypt (
    input  logic       clk,
    input  logic       init,
    input  logic       start,
    input  logic [2:0] taps_sel,
    input  logic [5:0] seed,
    input  logic [3:0] pre_len,
    input  logic [7:0] data_out,
    output logic [7:0] raddr,
    output logic [7:0] waddr,
    output logic [7:0] data_in,
    output logic       wr_en,
    output logic       done,
    output logic       err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_next;

    logic [5:0] r_cnt;
    logic [5:0] r_lfsr;
    logic [5:0] r_taps;
    logic [3:0] r_pre;
    logic       r_done;
    logic       r_err;

    logic       w_can_start;
    logic       w_accept;
    logic       w_reject;
    logic       w_last;
    logic       w_fb;
    logic       w_in_pre;
    logic [5:0] w_rd_idx;
    logic [5:0] w_seed_fix;
    logic [5:0] w_tap_val;

    always_comb begin
        w_tap_val = 6'h21;
        case (taps_sel)
            3'd0:    w_tap_val = 6'h21;
            3'd1:    w_tap_val = 6'h2D;
            3'd2:    w_tap_val = 6'h30;
            3'd3:    w_tap_val = 6'h33;
            3'd4:    w_tap_val = 6'h36;
            3'd5:    w_tap_val = 6'h39;
            default: w_tap_val = 6'h21;
        endcase
    end

    // Start is honoured in both IDLE and DONE; RUN ignores it entirely.
    assign w_can_start = (r_state != S_RUN) && start;
    assign w_accept    = w_can_start && (taps_sel <= 3'd5);
    assign w_reject    = w_can_start && (taps_sel > 3'd5);
    assign w_last      = (r_cnt == 6'd63);
    assign w_seed_fix  = (seed == 6'h00) ? 6'h01 : seed;
    assign w_fb        = ^(r_lfsr & r_taps);
    assign w_in_pre    = (r_cnt < {2'b00, r_pre});
    assign w_rd_idx    = r_cnt - {2'b00, r_pre};

    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_next = S_RUN;
            end
            S_RUN: begin
                if (w_last) w_next = S_DONE;
            end
            S_DONE: begin
                if (w_accept)      w_next = S_RUN;
                else if (w_reject) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        wr_en   = 1'b0;
        raddr   = 8'h00;
        waddr   = 8'h00;
        data_in = 8'h00;
        if (r_state == S_RUN) begin
            wr_en = 1'b1;
            waddr = 8'd64 + {2'b00, r_cnt};
            if (w_in_pre) begin
                data_in = 8'h5F ^ {2'b00, r_lfsr};
            end else begin
                raddr   = {2'b00, w_rd_idx};
                data_in = data_out ^ {2'b00, r_lfsr};
            end
        end
    end

    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            r_cnt  <= 6'd0;
            r_lfsr <= 6'h01;
            r_taps <= 6'h21;
            r_pre  <= 4'd0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
        end else if (w_accept) begin
            r_cnt  <= 6'd0;
            r_lfsr <= w_seed_fix;
            r_taps <= w_tap_val;
            r_pre  <= pre_len;
            r_done <= 1'b0;
            r_err  <= 1'b0;
        end else if (w_reject) begin
            r_done <= 1'b0;
            r_err  <= 1'b1;
        end else if (r_state == S_RUN) begin
            r_cnt  <= r_cnt + 6'd1;
            r_lfsr <= {r_lfsr[4:0], w_fb};
            if (w_last) r_done <= 1'b1;
        end
    end

    assign done = r_done;
    assign err  = r_err;

endmodule

// File: tb/tb_msg_encrypt.sv
// Scoreboarded bench for msg_encrypt: reference cipher model feeds a queue, negedge monitor checks every write.
module tb_msg_encrypt;

    logic       clk;
    logic       init;
    logic       start;
    logic [2:0] taps_sel;
    logic [5:0] seed;
    logic [3:0] pre_len;
    logic [7:0] data_out;
    logic [7:0] raddr;
    logic [7:0] waddr;
    logic [7:0] data_in;
    logic       wr_en;
    logic       done;
    logic       err;

    msg_encrypt dut (
        .clk      (clk),
        .init     (init),
        .start    (start),
        .taps_sel (taps_sel),
        .seed     (seed),
        .pre_len  (pre_len),
        .data_out (data_out),
        .raddr    (raddr),
        .waddr    (waddr),
        .data_in  (data_in),
        .wr_en    (wr_en),
        .done     (done),
        .err      (err)
    );

    typedef struct {
        logic [7:0] wa;
        logic [7:0] ra;
        logic [7:0] d;
    } exp_t;

    exp_t       q[$];
    logic [7:0] mem[256];
    logic [7:0] snap[256];
    int         lseq[64];
    int         tap_tbl[6] = '{33, 45, 48, 51, 54, 57};
    int         n_tests = 0;
    int         n_fail  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign data_out = mem[raddr];

    always @(posedge clk) begin
        if (wr_en) mem[waddr] <= data_in;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference cipher: parity of tapped bits shifted in at the LSB, one step per byte.
    task automatic build_exp(input int ts, input int sd, input int pl);
        int   s;
        int   b;
        exp_t e;
        s = (sd == 0) ? 1 : sd;
        for (int i = 0; i < 64; i++) begin
            lseq[i] = s;
            e.wa = 8'(64 + i);
            if (i < pl) begin
                e.ra = 8'h00;
                e.d  = 8'(95 ^ s);
            end else begin
                e.ra = 8'(i - pl);
                e.d  = mem[i - pl] ^ 8'(s);
            end
            q.push_back(e);
            b = $countones(s & tap_tbl[ts]) % 2;
            s = ((s * 2) % 64) + b;
        end
    endtask

    always @(negedge clk) begin
        if (wr_en) begin
            if (q.size() == 0) begin
                chk("unexpected_write", {24'h0, waddr}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("waddr", {24'h0, waddr}, {24'h0, e.wa});
                chk("raddr", {24'h0, raddr}, {24'h0, e.ra});
                chk("data_in", {24'h0, data_in}, {24'h0, e.d});
            end
        end
    end

    task automatic run_enc(input int ts, input int sd, input int pl, input bit perturb);
        int cyc;
        @(negedge clk);
        taps_sel = 3'(ts);
        seed     = 6'(sd);
        pre_len  = 4'(pl);
        build_exp(ts, sd, pl);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 0;
        while (!done && cyc < 200) begin
            if (perturb && cyc == 10) begin
                start    = 1'b1;
                taps_sel = 3'($urandom_range(0, 7));
                seed     = 6'($urandom);
                pre_len  = 4'($urandom);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        chk("done_latency", cyc, 64);
        chk("done_level", {31'h0, done}, 32'd1);
        chk("wr_en_in_done", {31'h0, wr_en}, 32'd0);
        chk("outs_zero_in_done", {8'h0, raddr, waddr, data_in}, 32'd0);
        chk("scoreboard_drained", q.size(), 0);
        q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        init     = 1'b1;
        start    = 1'b0;
        taps_sel = 3'd0;
        seed     = 6'h01;
        pre_len  = 4'd0;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);

        #12;
        chk("rst_wr_en", {31'h0, wr_en}, 32'd0);
        chk("rst_done", {31'h0, done}, 32'd0);
        chk("rst_err", {31'h0, err}, 32'd0);
        chk("rst_outs", {8'h0, raddr, waddr, data_in}, 32'd0);

        // Start held while in reset must be ignored.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        init  = 1'b0;
        repeat (3) @(negedge clk);
        chk("start_in_reset_done", {31'h0, done}, 32'd0);
        chk("start_in_reset_wr", {31'h0, wr_en}, 32'd0);

        run_enc(0, 6'h01, 7, 1'b0);
        chk("t0_mem64", {24'h0, mem[64]}, 32'h5E);
        chk("t0_mem65", {24'h0, mem[65]}, 32'h5C);

        mem[0] = 8'h41;
        run_enc(2, 6'h3F, 0, 1'b1);
        chk("t2_mem64", {24'h0, mem[64]}, 32'h7E);

        // Bad tap index, issued from DONE.
        @(negedge clk);
        taps_sel = 3'd6;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("reject_err", {31'h0, err}, 32'd1);
        chk("reject_done_clr", {31'h0, done}, 32'd0);
        repeat (5) @(negedge clk);
        chk("reject_err_hold", {31'h0, err}, 32'd1);
        chk("reject_no_wr", {31'h0, wr_en}, 32'd0);
        run_enc(1, $urandom_range(0, 63), $urandom_range(0, 15), 1'b0);
        chk("accept_err_clr", {31'h0, err}, 32'd0);

        run_enc(0, 6'h00, 1, 1'b0);
        chk("seed0_mem64", {24'h0, mem[64]}, 32'h5E);

        // Abort mid-run once cnt has reached 20.
        for (int i = 64; i < 128; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 256; i++) snap[i] = mem[i];
        @(negedge clk);
        taps_sel = 3'd3;
        seed     = 6'h2A;
        pre_len  = 4'd5;
        build_exp(3, 6'h2A, 5);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(posedge clk);
        #2;
        init = 1'b1;
        #1;
        chk("abort_wr_en_async", {31'h0, wr_en}, 32'd0);
        q.delete();
        repeat (2) @(negedge clk);
        chk("abort_done", {31'h0, done}, 32'd0);
        init = 1'b0;
        @(negedge clk);
        chk("abort_done_after", {31'h0, done}, 32'd0);
        for (int i = 85; i < 128; i++) chk("abort_mem_kept", {24'h0, mem[i]}, {24'h0, snap[i]});
        run_enc(3, 6'h2A, 5, 1'b0);

        // Round trip on every tap pattern.
        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
            run_enc(t, $urandom_range(0, 63), 10, 1'b1);
            for (int i = 0; i < 64; i++) begin
                logic [7:0] p;
                logic [7:0] want;
                p    = mem[64 + i] ^ 8'(lseq[i]);
                want = (i < 10) ? 8'h5F : mem[i - 10];
                chk("roundtrip", {24'h0, p}, {24'h0, want});
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
